alu_cmd_sequencer: RTL and testbench

//  Initiator side of the 16-bit ALU operand/opcode interface: accepts commands over valid/ready,

---
 rtl/alu_cmd_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_sequencer
// Description : Initiator for a combinational 16-bit ALU. Accepts a command
//               over valid/ready, presents registered operands/opcode to the
//               ALU, waits SETTLE cycles, captures result/carry and returns
//               it over valid/ready. Keeps an accumulator for chained ops.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_sequencer #(
  parameter int               WIDTH   = 16,
  parameter int               SETTLE  = 1,   // legal range 1..15
  parameter logic [WIDTH-1:0] ACC_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  // command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_use_acc,
  input  logic             cmd_wr_acc,
  // ALU interface
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_cout,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic             rsp_cout,
  output logic             rsp_zero,
  // accumulator
  output logic [WIDTH-1:0] acc
);

  // Counter is 4 bits wide, enough for the largest legal SETTLE of 15.
  localparam logic [3:0] c_settle_init = 4'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [3:0]       r_cnt;
  logic             r_wr_acc;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [2:0]       r_alu_op;
  logic [WIDTH-1:0] r_rsp_y;
  logic             r_rsp_cout;
  logic             r_rsp_zero;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_capture;
  logic             w_cnt_zero;
  logic             w_carry_op;

  assign w_cnt_zero = (r_cnt == 4'd0);
  // Only add (000) and sub (001) produce a meaningful carry/borrow.
  assign w_carry_op = (r_alu_op[2:1] == 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake decode; outputs derived purely from state.
  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept     = 1'b1;
          w_next_state = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (w_cnt_zero) begin
          w_capture    = 1'b1;
          w_next_state = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        // Return to IDLE only; a new command waits for the following cycle.
        if (rsp_ready) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Settle counter: loaded at accept, counts down while waiting on the ALU.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (w_accept) begin
      r_cnt <= c_settle_init;
    end else if ((r_state == ST_SETTLE) && !w_cnt_zero) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  // ALU operand/opcode registers; they change only when a command is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_alu_op <= 3'b000;
      r_wr_acc <= 1'b0;
    end else if (w_accept) begin
      r_alu_a  <= cmd_use_acc ? r_acc : cmd_a;
      r_alu_b  <= cmd_b;
      r_alu_op <= cmd_op;
      r_wr_acc <= cmd_wr_acc;
    end
  end

  // Response capture; values hold until the next capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_y    <= '0;
      r_rsp_cout <= 1'b0;
      r_rsp_zero <= 1'b0;
    end else if (w_capture) begin
      r_rsp_y    <= alu_y;
      r_rsp_cout <= w_carry_op ? alu_cout : 1'b0;
      r_rsp_zero <= (alu_y == '0);
    end
  end

  // Accumulator: written with the captured result when the command asked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= ACC_RST;
    end else if (w_capture && r_wr_acc) begin
      r_acc <= alu_y;
    end
  end

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_op   = r_alu_op;
  assign rsp_y    = r_rsp_y;
  assign rsp_cout = r_rsp_cout;
  assign rsp_zero = r_rsp_zero;
  assign acc      = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_sequencer
// Description : Self-checking bench for alu_cmd_sequencer. One instance with
//               SETTLE=1 runs a vector table plus a backpressure sequence;
//               a second with SETTLE=4 covers latency and mid-op reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_sequencer;

  localparam logic [15:0] c_acc_rst4 = 16'h00A5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- instance with SETTLE=1 ----------------
  logic        cmd_valid1 = 1'b0, cmd_ready1, cmd_use_acc1 = 1'b0, cmd_wr_acc1 = 1'b0;
  logic [2:0]  cmd_op1 = 3'd0, alu_op1;
  logic [15:0] cmd_a1 = '0, cmd_b1 = '0, alu_a1, alu_b1, alu_y1, rsp_y1, acc1;
  logic        alu_cout1, rsp_valid1, rsp_ready1 = 1'b0, rsp_cout1, rsp_zero1;

  // ---------------- instance with SETTLE=4 ----------------
  logic        cmd_valid4 = 1'b0, cmd_ready4, cmd_use_acc4 = 1'b0, cmd_wr_acc4 = 1'b0;
  logic [2:0]  cmd_op4 = 3'd0, alu_op4;
  logic [15:0] cmd_a4 = '0, cmd_b4 = '0, alu_a4, alu_b4, alu_y4, rsp_y4, acc4;
  logic        alu_cout4, rsp_valid4, rsp_ready4 = 1'b0, rsp_cout4, rsp_zero4;

  logic force_cout = 1'b0;

  alu_cmd_sequencer #(.WIDTH(16), .SETTLE(1), .ACC_RST(16'h0000)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_op(cmd_op1),
    .cmd_a(cmd_a1), .cmd_b(cmd_b1), .cmd_use_acc(cmd_use_acc1), .cmd_wr_acc(cmd_wr_acc1),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_op(alu_op1), .alu_y(alu_y1), .alu_cout(alu_cout1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_y(rsp_y1),
    .rsp_cout(rsp_cout1), .rsp_zero(rsp_zero1), .acc(acc1)
  );

  alu_cmd_sequencer #(.WIDTH(16), .SETTLE(4), .ACC_RST(c_acc_rst4)) u_dut4 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_op(cmd_op4),
    .cmd_a(cmd_a4), .cmd_b(cmd_b4), .cmd_use_acc(cmd_use_acc4), .cmd_wr_acc(cmd_wr_acc4),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_op(alu_op4), .alu_y(alu_y4), .alu_cout(alu_cout4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_y(rsp_y4),
    .rsp_cout(rsp_cout4), .rsp_zero(rsp_zero4), .acc(acc4)
  );

  // Behavioural ALU: carry from add, borrow from sub, force_cout elsewhere.
  function automatic logic [16:0] alu_f(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic fc);
    case (op)
      3'd0:    alu_f = {1'b0, a} + {1'b0, b};
      3'd1:    alu_f = {(a < b), a - b};
      3'd2:    alu_f = {fc, (a > b) ? a : b};
      3'd3:    alu_f = {fc, (a < b) ? a : b};
      3'd4:    alu_f = {fc, a & b};
      3'd5:    alu_f = {fc, a | b};
      3'd6:    alu_f = {fc, a ^ b};
      default: alu_f = {fc, ~(a ^ b)};
    endcase
  endfunction

  assign {alu_cout1, alu_y1} = alu_f(alu_op1, alu_a1, alu_b1, force_cout);
  assign {alu_cout4, alu_y4} = alu_f(alu_op4, alu_a4, alu_b4, force_cout);

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        use_acc;
    logic        wr_acc;
    logic        fc;
    logic [15:0] exp_alu_a;
    logic [15:0] exp_y;
    logic        exp_cout;
    logic        exp_zero;
    logic [15:0] exp_acc;
  } vec_t;

  vec_t vecs[13];

  // Present one command to the SETTLE=1 instance and finish its accept edge.
  task automatic issue1(input string tag, input logic [2:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic use_acc, input logic wr_acc);
    @(negedge clk);
    cmd_op1 = op; cmd_a1 = a; cmd_b1 = b;
    cmd_use_acc1 = use_acc; cmd_wr_acc1 = wr_acc; cmd_valid1 = 1'b1;
    chk({tag, "_cmd_ready_idle"}, 32'(cmd_ready1), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid1 = 1'b0;
  endtask

  // Count clock edges after the accept edge until rsp_valid, bounded.
  task automatic wait_rsp1(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!rsp_valid1 && lat < 20);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int    lat;
    string t;
    t = $sformatf("v%0d", idx);
    force_cout = v.fc;
    issue1(t, v.op, v.a, v.b, v.use_acc, v.wr_acc);
    chk({t, "_alu_a"}, 32'(alu_a1), 32'(v.exp_alu_a));
    chk({t, "_alu_b"}, 32'(alu_b1), 32'(v.b));
    chk({t, "_alu_op"}, 32'(alu_op1), 32'(v.op));
    chk({t, "_busy_ready"}, 32'(cmd_ready1), 32'd0);
    wait_rsp1(lat);
    chk({t, "_latency"}, 32'(lat), 32'd1);
    chk({t, "_rsp_y"}, 32'(rsp_y1), 32'(v.exp_y));
    chk({t, "_rsp_cout"}, 32'(rsp_cout1), 32'(v.exp_cout));
    chk({t, "_rsp_zero"}, 32'(rsp_zero1), 32'(v.exp_zero));
    chk({t, "_acc"}, 32'(acc1), 32'(v.exp_acc));
    rsp_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready1 = 1'b0;
    chk({t, "_rsp_done"}, 32'(rsp_valid1), 32'd0);
    chk({t, "_back_idle"}, 32'(cmd_ready1), 32'd1);
    force_cout = 1'b0;
  endtask

  initial begin
    int lat;
    int seen;

    //            op    a        b        ua    wa    fc    alu_a    y        co    z     acc
    vecs[0]  = '{3'd0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 1'b1, 16'h0000};
    vecs[1]  = '{3'd1, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b0, 16'h0003, 16'hFFFE, 1'b1, 1'b0, 16'h0000};
    vecs[2]  = '{3'd6, 16'h00FF, 16'h0F0F, 1'b0, 1'b0, 1'b1, 16'h00FF, 16'h0FF0, 1'b0, 1'b0, 16'h0000};
    vecs[3]  = '{3'd0, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h000C, 1'b0, 1'b0, 16'h000C};
    vecs[4]  = '{3'd0, 16'h1234, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h000C, 16'h000D, 1'b0, 1'b0, 16'h000C};
    vecs[5]  = '{3'd2, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h000C};
    vecs[6]  = '{3'd3, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b0, 1'b0, 16'h000C};
    vecs[7]  = '{3'd4, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h0220, 1'b0, 1'b0, 16'h000C};
    vecs[8]  = '{3'd5, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, 16'h1234, 16'h5335, 1'b0, 1'b0, 16'h000C};
    vecs[9]  = '{3'd7, 16'h00FF, 16'h00FF, 1'b0, 1'b0, 1'b1, 16'h00FF, 16'hFFFF, 1'b0, 1'b0, 16'h000C};
    vecs[10] = '{3'd1, 16'h0005, 16'h0005, 1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000, 1'b0, 1'b1, 16'h0000};
    vecs[11] = '{3'd1, 16'h7777, 16'h0001, 1'b1, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000};
    vecs[12] = '{3'd1, 16'h0007, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0007, 16'h0005, 1'b0, 1'b0, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready1), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    chk("rst_rsp_y", 32'(rsp_y1), 32'd0);
    chk("rst_rsp_cout", 32'(rsp_cout1), 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero1), 32'd0);
    chk("rst_alu_a", 32'(alu_a1), 32'd0);
    chk("rst_alu_b", 32'(alu_b1), 32'd0);
    chk("rst_alu_op", 32'(alu_op1), 32'd0);
    chk("rst_acc1", 32'(acc1), 32'd0);
    chk("rst_acc4", 32'(acc4), 32'(c_acc_rst4));
    rst_n = 1'b1;

    // Table-driven vectors on the SETTLE=1 instance
    for (int i = 0; i < 13; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: response held, new command ignored, no accept at handshake
    issue1("bp", 3'd0, 16'hFF00, 16'h0123, 1'b0, 1'b0);
    wait_rsp1(lat);
    chk("bp_latency", 32'(lat), 32'd1);
    cmd_op1 = 3'd6; cmd_a1 = 16'hAAAA; cmd_b1 = 16'h5555; cmd_valid1 = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp%0d_rsp_y", c), 32'(rsp_y1), 32'h0023);
      chk($sformatf("bp%0d_rsp_cout", c), 32'(rsp_cout1), 32'd1);
      chk($sformatf("bp%0d_rsp_valid", c), 32'(rsp_valid1), 32'd1);
      chk($sformatf("bp%0d_cmd_ready", c), 32'(cmd_ready1), 32'd0);
      chk($sformatf("bp%0d_alu_a", c), 32'(alu_a1), 32'hFF00);
    end
    rsp_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready1 = 1'b0;
    chk("bp_rsp_done", 32'(rsp_valid1), 32'd0);
    chk("bp_idle", 32'(cmd_ready1), 32'd1);
    chk("bp_no_accept_a", 32'(alu_a1), 32'hFF00);
    chk("bp_no_accept_op", 32'(alu_op1), 32'd0);
    cmd_valid1 = 1'b0;

    // SETTLE=4 instance: latency and accumulator write
    @(negedge clk);
    cmd_op4 = 3'd0; cmd_a4 = 16'h0002; cmd_b4 = 16'h0003;
    cmd_use_acc4 = 1'b0; cmd_wr_acc4 = 1'b1; cmd_valid4 = 1'b1;
    chk("s4_ready", 32'(cmd_ready4), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid4 = 1'b0;
    chk("s4_alu_a", 32'(alu_a4), 32'h0002);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!rsp_valid4) chk($sformatf("s4_busy%0d", lat), 32'(cmd_ready4), 32'd0);
    end while (!rsp_valid4 && lat < 20);
    chk("s4_latency", 32'(lat), 32'd4);
    chk("s4_rsp_y", 32'(rsp_y4), 32'h0005);
    chk("s4_rsp_cout", 32'(rsp_cout4), 32'd0);
    chk("s4_acc", 32'(acc4), 32'h0005);
    rsp_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready4 = 1'b0;
    chk("s4_idle", 32'(cmd_ready4), 32'd1);

    // Reset two cycles into a command: abandoned, acc restored
    cmd_op4 = 3'd0; cmd_a4 = 16'h0000; cmd_b4 = 16'h0001;
    cmd_use_acc4 = 1'b1; cmd_wr_acc4 = 1'b1; cmd_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid4 = 1'b0;
    chk("rs_alu_a", 32'(alu_a4), 32'h0005);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rs_acc_async", 32'(acc4), 32'(c_acc_rst4));
    chk("rs_ready_async", 32'(cmd_ready4), 32'd1);
    chk("rs_valid_async", 32'(rsp_valid4), 32'd0);
    chk("rs_alu_a_async", 32'(alu_a4), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid4) seen++;
    end
    chk("rs_no_rsp", 32'(seen), 32'd0);
    chk("rs_acc", 32'(acc4), 32'(c_acc_rst4));
    chk("rs_ready", 32'(cmd_ready4), 32'd1);
    chk("rs_acc1", 32'(acc1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
